exec_md_stage: RTL and testbench
================================

Name: exec_md_stage

Overview:
- Parametrised next-generation execute stage for the five-stage MIPS pipeline.
- Keeps the E-stage operand forwarding, ALU-B source select and ALU.
- Adds a multi-cycle multiply/divide unit with HI/LO registers, mthi/mtlo/mfhi/mflo support, and busy/start outputs that the hazard unit uses for stalling.
- Sits between the D/E and E/M pipeline registers; its result feeds the E/M register.

Parameters:
WIDTH, 32, datapath width in bits
MULT_CYCLES, 5, busy cycles for mult/multu (minimum 1)
DIV_CYCLES, 10, busy cycles for div/divu (minimum 1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
rd1, rd2  input  WIDTH  register-file operands latched in D/E
imm  input  WIDTH  extended immediate
res_m, res_w, memrd_w  input  WIDTH  forwarding sources: M result, W ALU result, W load data
pc4_m, pc4_w  input  WIDTH  PC+4 of the M and W instructions; PC+8 is forwarded for links
fwd_a_sel, fwd_b_sel  input  3  forwarding select: 0 rd, 1 memrd_w, 2 res_w, 3 res_m, 4 pc4_w+4, 5 pc4_m+4, 6/7 rd
alu_src  input  1  ALU B: 0 forwarded B, 1 imm
alu_op  input  3  0 add, 1 sub, 2 or, 3 and, 4 slt, 5 sltu, 6 lui (B<<16), 7 xor
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
res_src  input  2  result select: 0 ALU, 1 HI (mfhi), 2 LO (mflo), 3 ALU
e_valid  input  1  E holds a real instruction (0 = bubble)
res  output  WIDTH  E-stage result
fwd_b  output  WIDTH  forwarded B, used as store data
start  output  1  combinational: a mult/div is accepted this cycle
busy  output  1  registered: mult/div is in progress
hi, lo  output  WIDTH  current HI/LO register values

Behaviour:
- Forwarding muxes, ALU and the result mux are combinational: zero latency.
- All arithmetic wraps modulo 2^WIDTH; no overflow trap.
- slt compares signed and gives 1/0 zero-extended; sltu compares unsigned.
- Reset (async, reset=0):
  - state IDLE, busy=0, hi=0, lo=0, counter=0.
  - An in-flight operation is discarded and never writes HI/LO.
- States:
  - IDLE -> MULT: start with md_op 1/2.
  - IDLE -> DIV: start with md_op 3/4.
  - MULT/DIV -> IDLE: when the counter reaches its final count.
- start = e_valid & !busy & md_op in {1..4}.
  - On the start edge: latch both forwarded operands and the op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; busy goes 1.
- busy stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - On the edge where busy falls, HI/LO take the result.
  - A mfhi/mflo in the following cycle sees the new value.
- mult: signed 2*WIDTH-bit product. multu: unsigned. HI = upper half, LO = lower half.
- div (signed):
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Special case: INT_MIN / -1 gives LO = INT_MIN, HI = 0.
- divu: unsigned quotient and remainder.
- Divisor zero (div or divu): the full busy period still elapses; HI/LO are left unchanged.
- mthi/mtlo: write forwarded A into HI/LO on the next edge when e_valid & !busy.
  - Ignored while busy; the hazard unit must stall them.
- md_op 1..4 while busy: ignored; no restart and no corruption of the running operation.
  - Hazard unit stalls on (busy | start) & instruction in D uses HI/LO.
- e_valid=0: no start, no mthi/mtlo write, whatever md_op is.
- res_src 1/2 returns HI/LO as currently registered, including during busy (old value).

Decomposition:
- Shared package: ALU_OP, MD_OP, FWD_SEL and RES_SRC encodings as named constants.
- Sub-module md_unit holds the state machine, counter, operand latch, HI/LO and the mult/div arithmetic.
  - It may compute the result at start and hold it until completion, or iterate; only the visible timing is specified.
- Top level holds the forwarding muxes, ALU-B select, ALU and result mux.

Test Plan:
- fwd_a_sel=3, res_m=0x00001234, alu_src=1, imm=1, alu_op=add -> res=0x00001235; fwd_b_sel=5, pc4_m=0x3004 -> fwd_b=0x3008.
- mult A=0xFFFFFFFF, B=2, e_valid=1 -> start=1 that cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu -> HI=1, LO=0xFFFFFFFE.
- div A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu by 0 with HI=0xAA -> busy 10 cycles, then HI=0xAA and LO unchanged.
- mthi A=0x55 when idle; next cycle res_src=1 -> res=0x55. mtlo issued while busy -> LO unaffected by it.
- Start div; assert reset=0 in busy cycle 4 -> busy=0, HI=LO=0 immediately. After reset is released, no late HI/LO write.
- md_op=mult with e_valid=0 -> start=0, busy stays 0. A second mult while busy -> operation count and result equal those of the first.

Source files
------------

// File: rtl/exec_md_stage_pkg.sv
// Shared encodings for the MIPS execute stage: ALU ops, mult/div ops,
// forwarding selects, result selects and the mult/div unit state.
package exec_md_stage_pkg;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_SLT  = 3'd4;
   localparam logic [2:0] ALU_SLTU = 3'd5;
   localparam logic [2:0] ALU_LUI  = 3'd6;
   localparam logic [2:0] ALU_XOR  = 3'd7;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [2:0] FWD_RD      = 3'd0;
   localparam logic [2:0] FWD_MEMRD_W = 3'd1;
   localparam logic [2:0] FWD_RES_W   = 3'd2;
   localparam logic [2:0] FWD_RES_M   = 3'd3;
   localparam logic [2:0] FWD_PC8_W   = 3'd4;
   localparam logic [2:0] FWD_PC8_M   = 3'd5;

   localparam logic [1:0] RES_ALU  = 2'd0;
   localparam logic [1:0] RES_HI   = 2'd1;
   localparam logic [1:0] RES_LO   = 2'd2;
   localparam logic [1:0] RES_ALU3 = 2'd3;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY_MULT = 2'd1,
      MD_BUSY_DIV = 2'd2
   } md_state_e;

endpackage

// File: rtl/exec_md_stage_md_unit.sv
// Multi-cycle multiply/divide unit: operand latch, busy counter, HI/LO.
// The result is computed from the latched operands and committed when busy falls.
module md_unit
   import exec_md_stage_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             e_valid,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
   logic [2:0]       r_op;
   logic             w_is_md, w_start, w_done, w_is_div, w_b_zero, w_wr_res;
   logic signed [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0]        w_prod_u;
   logic signed [WIDTH-1:0]   w_sdivisor, w_squo, w_srem;
   logic [WIDTH-1:0]          w_udivisor, w_uquo, w_urem;
   logic [2*WIDTH-1:0]        w_res;

   always_comb begin
      w_is_md  = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                 (md_op == MD_DIV)  || (md_op == MD_DIVU);
      w_start  = e_valid && (r_state == MD_IDLE) && w_is_md;
      w_done   = (r_state != MD_IDLE) && (r_cnt == CNT_ONE);
      w_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
      w_b_zero = (r_b == '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         MD_IDLE: begin
            if (w_start) begin
               if ((md_op == MD_MULT) || (md_op == MD_MULTU)) begin
                  w_state_nxt = MD_BUSY_MULT;
                  w_cnt_nxt   = MULT_LOAD;
               end else begin
                  w_state_nxt = MD_BUSY_DIV;
                  w_cnt_nxt   = DIV_LOAD;
               end
            end
         end
         MD_BUSY_MULT, MD_BUSY_DIV: begin
            if (w_done) begin
               w_state_nxt = MD_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_start) begin
         r_a  <= a;
         r_b  <= b;
         r_op <= md_op;
      end
   end

   // A zero divisor or INT_MIN/-1 divides by 1 instead: keeps the divider
   // defined and yields LO=INT_MIN, HI=0 for the overflow case.
   always_comb begin
      w_prod_s   = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
      w_prod_u   = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
      w_sdivisor = (w_b_zero || ((r_a == INT_MIN) && (r_b == '1))) ? WIDTH'(1) : $signed(r_b);
      w_squo     = $signed(r_a) / w_sdivisor;
      w_srem     = $signed(r_a) % w_sdivisor;
      w_udivisor = w_b_zero ? WIDTH'(1) : r_b;
      w_uquo     = r_a / w_udivisor;
      w_urem     = r_a % w_udivisor;
      case (r_op)
         MD_MULT:  w_res = w_prod_s;
         MD_MULTU: w_res = w_prod_u;
         MD_DIV:   w_res = {w_srem, w_squo};
         MD_DIVU:  w_res = {w_urem, w_uquo};
         default:  w_res = '0;
      endcase
      w_wr_res = w_done && !(w_is_div && w_b_zero);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_wr_res) begin
         r_hi <= w_res[2*WIDTH-1:WIDTH];
         r_lo <= w_res[WIDTH-1:0];
      end else if (e_valid && (r_state == MD_IDLE)) begin
         if (md_op == MD_MTHI) r_hi <= a;
         if (md_op == MD_MTLO) r_lo <= a;
      end
   end

   assign start = w_start;
   assign busy  = (r_state != MD_IDLE);
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: rtl/exec_md_stage.sv
// MIPS execute stage: operand forwarding, ALU-B select, ALU, result mux,
// plus the multi-cycle mult/div unit feeding HI/LO.
module exec_md_stage
   import exec_md_stage_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] res_m,
   input  logic [WIDTH-1:0] res_w,
   input  logic [WIDTH-1:0] memrd_w,
   input  logic [WIDTH-1:0] pc4_m,
   input  logic [WIDTH-1:0] pc4_w,
   input  logic [2:0]       fwd_a_sel,
   input  logic [2:0]       fwd_b_sel,
   input  logic             alu_src,
   input  logic [2:0]       alu_op,
   input  logic [2:0]       md_op,
   input  logic [1:0]       res_src,
   input  logic             e_valid,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] fwd_b,
   output logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   logic [WIDTH-1:0]        w_fwd_a, w_fwd_b, w_alu_b, w_alu;
   logic signed [WIDTH-1:0] w_sa, w_sb;
   logic [WIDTH-1:0]        w_hi, w_lo;
   logic                    w_start, w_busy;

   // Link instructions in M/W forward their PC+8, i.e. the stored PC+4 plus 4.
   function automatic logic [WIDTH-1:0] fwd_mux(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] rd,
      input logic [WIDTH-1:0] f_memrd_w,
      input logic [WIDTH-1:0] f_res_w,
      input logic [WIDTH-1:0] f_res_m,
      input logic [WIDTH-1:0] f_pc4_w,
      input logic [WIDTH-1:0] f_pc4_m
   );
      case (sel)
         FWD_MEMRD_W: return f_memrd_w;
         FWD_RES_W:   return f_res_w;
         FWD_RES_M:   return f_res_m;
         FWD_PC8_W:   return f_pc4_w + PC_STEP;
         FWD_PC8_M:   return f_pc4_m + PC_STEP;
         default:     return rd;
      endcase
   endfunction

   always_comb begin
      w_fwd_a = fwd_mux(fwd_a_sel, rd1, memrd_w, res_w, res_m, pc4_w, pc4_m);
      w_fwd_b = fwd_mux(fwd_b_sel, rd2, memrd_w, res_w, res_m, pc4_w, pc4_m);
      w_alu_b = alu_src ? imm : w_fwd_b;
      w_sa    = $signed(w_fwd_a);
      w_sb    = $signed(w_alu_b);
      case (alu_op)
         ALU_ADD:  w_alu = w_fwd_a + w_alu_b;
         ALU_SUB:  w_alu = w_fwd_a - w_alu_b;
         ALU_OR:   w_alu = w_fwd_a | w_alu_b;
         ALU_AND:  w_alu = w_fwd_a & w_alu_b;
         ALU_SLT:  w_alu = (w_sa < w_sb) ? WIDTH'(1) : '0;
         ALU_SLTU: w_alu = (w_fwd_a < w_alu_b) ? WIDTH'(1) : '0;
         ALU_LUI:  w_alu = w_alu_b << 16;
         default:  w_alu = w_fwd_a ^ w_alu_b;
      endcase
      case (res_src)
         RES_HI:  res = w_hi;
         RES_LO:  res = w_lo;
         default: res = w_alu;
      endcase
   end

   md_unit #(
      .WIDTH      (WIDTH),
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md (
      .clk    (clk),
      .reset  (reset),
      .e_valid(e_valid),
      .md_op  (md_op),
      .a      (w_fwd_a),
      .b      (w_fwd_b),
      .start  (w_start),
      .busy   (w_busy),
      .hi     (w_hi),
      .lo     (w_lo)
   );

   assign fwd_b = w_fwd_b;
   assign start = w_start;
   assign busy  = w_busy;
   assign hi    = w_hi;
   assign lo    = w_lo;

endmodule

// File: tb/tb_exec_md_stage.sv
// Directed self-checking bench for exec_md_stage (WIDTH=32, 5-cycle mult, 10-cycle div).
module tb_exec_md_stage;
   import exec_md_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rd1, rd2, imm, res_m, res_w, memrd_w, pc4_m, pc4_w;
   logic [2:0]  fwd_a_sel, fwd_b_sel, alu_op, md_op;
   logic        alu_src, e_valid;
   logic [1:0]  res_src;
   logic [31:0] res, fwd_b, hi, lo;
   logic        start, busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   exec_md_stage #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .rd1(rd1), .rd2(rd2), .imm(imm),
      .res_m(res_m), .res_w(res_w), .memrd_w(memrd_w), .pc4_m(pc4_m), .pc4_w(pc4_w),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .alu_src(alu_src), .alu_op(alu_op),
      .md_op(md_op), .res_src(res_src), .e_valid(e_valid),
      .res(res), .fwd_b(fwd_b), .start(start), .busy(busy), .hi(hi), .lo(lo)
   );

   task automatic set_defaults();
      rd1 = '0; rd2 = '0; imm = '0; res_m = '0; res_w = '0; memrd_w = '0;
      pc4_m = '0; pc4_w = '0; fwd_a_sel = FWD_RD; fwd_b_sel = FWD_RD;
      alu_src = 1'b0; alu_op = ALU_ADD; md_op = MD_NONE; res_src = RES_ALU; e_valid = 1'b0;
   endtask

   // Counts negedges with busy high, bounded so a stuck busy cannot hang the run.
   task automatic wait_busy(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   // Issues one mult/div op for a single cycle, then waits for it to finish.
   task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic st, output int cycles);
      @(negedge clk);
      rd1 = a; rd2 = b; md_op = op; e_valid = 1'b1;
      #1 st = start;
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0;
      wait_busy(cycles);
   endtask

   task automatic test_reset();
      set_defaults();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fwd_alu();
      logic [2:0]  ops [8];
      logic [31:0] exp [8];
      logic [2:0]  sels [5];
      logic [31:0] sexp [5];
      @(negedge clk);
      set_defaults();
      fwd_a_sel = FWD_RES_M; res_m = 32'h0000_1234; alu_src = 1'b1; imm = 32'h1; alu_op = ALU_ADD;
      fwd_b_sel = FWD_PC8_M; pc4_m = 32'h0000_3004;
      #1;
      n_cmp++; if (res !== 32'h0000_1235) begin n_bad++; $display("FAIL fwd_resm_add: got %h want 00001235", res); end
      n_cmp++; if (fwd_b !== 32'h0000_3008) begin n_bad++; $display("FAIL fwd_b_pc8m: got %h want 00003008", fwd_b); end

      ops = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_XOR};
      exp = '{32'h0000_0000, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'h0000_0010,
              32'h0000_0001, 32'h0000_0000, 32'h0010_0000, 32'hFFFF_FFE0};
      set_defaults();
      rd1 = 32'hFFFF_FFF0; rd2 = 32'h0000_0010;
      for (int i = 0; i < 8; i++) begin
         alu_op = ops[i];
         #1;
         n_cmp++;
         if (res !== exp[i]) begin
            n_bad++; $display("FAIL alu_op%0d: got %h want %h", ops[i], res, exp[i]);
         end
      end

      sels = '{FWD_MEMRD_W, FWD_RES_W, FWD_PC8_W, 3'd6, 3'd7};
      sexp = '{32'h1111_0000, 32'h2222_0000, 32'h0000_4004, 32'hCAFE_0001, 32'hCAFE_0001};
      set_defaults();
      rd1 = 32'hCAFE_0001; memrd_w = 32'h1111_0000; res_w = 32'h2222_0000; pc4_w = 32'h0000_4000;
      alu_src = 1'b1; imm = '0; alu_op = ALU_ADD;
      for (int i = 0; i < 5; i++) begin
         fwd_a_sel = sels[i];
         #1;
         n_cmp++;
         if (res !== sexp[i]) begin
            n_bad++; $display("FAIL fwd_a_sel%0d: got %h want %h", sels[i], res, sexp[i]);
         end
      end
      set_defaults();
   endtask

   task automatic test_mult();
      logic st;
      int   cyc;
      issue_md(MD_MULT, 32'hFFFF_FFFF, 32'h2, st, cyc);
      n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL mult_start: got %b want 1", st); end
      n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
      res_src = RES_LO; #1;
      n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mflo_after_mult: got %h want fffffffe", res); end
      res_src = RES_ALU;

      issue_md(MD_MULTU, 32'hFFFF_FFFF, 32'h2, st, cyc);
      n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 5", cyc); end
      n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
   endtask

   task automatic test_div();
      logic st;
      int   cyc;
      issue_md(MD_DIV, 32'hFFFF_FFF9, 32'h2, st, cyc);
      n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end

      issue_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, cyc);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
      n_cmp++; if (hi !== 32'h0000_0000) begin n_bad++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end

      issue_md(MD_DIVU, 32'hFFFF_FFF9, 32'h2, st, cyc);
      n_cmp++; if (lo !== 32'h7FFF_FFFC) begin n_bad++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
      n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL divu_hi: got %h want 00000001", hi); end
   endtask

   task automatic test_div_zero();
      logic st;
      int   cyc;
      @(negedge clk);
      rd1 = 32'hAA; md_op = MD_MTHI; e_valid = 1'b1;
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0;
      issue_md(MD_DIVU, 32'h5, 32'h0, st, cyc);
      n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divu0_busy_cycles: got %0d want 10", cyc); end
      n_cmp++; if (hi !== 32'h0000_00AA) begin n_bad++; $display("FAIL divu0_hi: got %h want 000000aa", hi); end
      n_cmp++; if (lo !== 32'h7FFF_FFFC) begin n_bad++; $display("FAIL divu0_lo: got %h want 7ffffffc", lo); end
      issue_md(MD_DIV, 32'h9, 32'h0, st, cyc);
      n_cmp++; if (hi !== 32'h0000_00AA) begin n_bad++; $display("FAIL div0_hi: got %h want 000000aa", hi); end
   endtask

   task automatic test_mthi_mtlo();
      int cyc;
      @(negedge clk);
      rd1 = 32'h55; md_op = MD_MTHI; e_valid = 1'b1;
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0; res_src = RES_HI;
      #1;
      n_cmp++; if (res !== 32'h0000_0055) begin n_bad++; $display("FAIL mfhi_after_mthi: got %h want 00000055", res); end
      res_src = RES_ALU;

      @(negedge clk);
      rd1 = 32'h3; rd2 = 32'h4; md_op = MD_MULT; e_valid = 1'b1;
      @(negedge clk);
      rd1 = 32'h99; md_op = MD_MTLO; e_valid = 1'b1; res_src = RES_LO;
      #1;
      n_cmp++; if (res !== 32'h7FFF_FFFC) begin n_bad++; $display("FAIL mflo_during_busy: got %h want 7ffffffc", res); end
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0; res_src = RES_ALU;
      wait_busy(cyc);
      n_cmp++; if (lo !== 32'h0000_000C) begin n_bad++; $display("FAIL mtlo_while_busy_lo: got %h want 0000000c", lo); end
      n_cmp++; if (hi !== 32'h0000_0000) begin n_bad++; $display("FAIL mult34_hi: got %h want 00000000", hi); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      rd1 = 32'h11; md_op = MD_MTHI; e_valid = 1'b1;
      @(negedge clk);
      rd1 = 32'd100; rd2 = 32'd7; md_op = MD_DIV; e_valid = 1'b1;
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midop_reset_busy: got %b want 0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL midop_reset_hi: got %h want 00000000", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL midop_reset_lo: got %h want 00000000", lo); end
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin
         n_bad++; $display("FAIL no_late_write: got hi=%h lo=%h want 0/0", hi, lo);
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL after_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_evalid();
      @(negedge clk);
      rd1 = 32'h3; rd2 = 32'h3; md_op = MD_MULT; e_valid = 1'b0;
      #1;
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL bubble_start: got %b want 0", start); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bubble_busy: got %b want 0", busy); end
      rd1 = 32'h77; md_op = MD_MTHI;
      @(negedge clk);
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL bubble_mthi: got %h want 00000000", hi); end
      md_op = MD_NONE;
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      rd1 = 32'd3; rd2 = 32'd5; md_op = MD_MULT; e_valid = 1'b1;
      @(negedge clk);
      rd1 = 32'd7; rd2 = 32'd9; md_op = MD_MULT; e_valid = 1'b1;
      #1;
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL b2b_start_while_busy: got %b want 0", start); end
      @(negedge clk);
      md_op = MD_NONE; e_valid = 1'b0;
      wait_busy(cyc);
      n_cmp++; if (cyc + 1 != 5) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 5", cyc + 1); end
      n_cmp++; if (lo !== 32'd15) begin n_bad++; $display("FAIL b2b_lo: got %h want 0000000f", lo); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL b2b_hi: got %h want 00000000", hi); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_no_restart: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_fwd_alu();
      test_mult();
      test_div();
      test_div_zero();
      test_mthi_mtlo();
      test_reset_midop();
      test_evalid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
